// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-stage controller for a 16-bit external SRAM.
// Splits each 32-bit load/store from the EXE/MEM register into two halfword accesses
// (low halfword first), each phase held WAIT_CYCLES+1 cycles, and freezes the pipeline
// until the transaction finishes.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_read/write    request from EXE/MEM register (write wins if both are set)
//   addr, wdata       byte address and store data
//   rdata             load data, held until the next read capture
//   ready, freeze     pipeline may advance / pipeline hold (freeze = ~ready)
//   sram_*            halfword address, active-low write enable, write data + output enable,
//                     read data
//   stall_count       saturating count of freeze cycles
//
// Optional feature: define SRAM_STALL_CNT_EN to build the stall counter; otherwise
// stall_count is tied to zero.

module mem_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic [31:0]        stall_count
);

  localparam int unsigned WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WaitLast = WW'(WAIT_CYCLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               op_we_q, op_we_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic req, in_phase, last;

  assign req      = mem_read | mem_write;
  assign in_phase = (state_q == StLo) || (state_q == StHi);
  assign last     = (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_we_d = op_we_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          op_we_d = mem_write;
          word_d  = (SRAM_AW-1)'((addr - BASE_ADDR) >> 2);
          wdata_d = wdata;
          wait_d  = '0;
          state_d = StLo;
        end
      end
      StLo: begin
        if (last) begin
          wait_d  = '0;
          state_d = StHi;
          if (!op_we_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHi: begin
        if (last) begin
          wait_d  = '0;
          state_d = StDone;
          if (!op_we_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      // Always pass through idle so a request still held after completion is seen fresh.
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      op_we_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_we_q <= op_we_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins decode straight from state so reset releases them without waiting for a clock.
  always_comb begin
    ready       = (state_q == StIdle) ? ~req : (state_q == StDone);
    freeze      = ~ready;
    rdata       = rdata_q;
    sram_addr   = in_phase ? {word_q, (state_q == StHi)} : '0;
    sram_dq_oe  = in_phase & op_we_q;
    sram_dq_out = sram_dq_oe ? ((state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0;
    // Last cycle of a phase holds data with we_n released, unless the phase is one cycle long.
    sram_we_n   = ~(in_phase & op_we_q & (~last | (WAIT_CYCLES == 0)));
  end

`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (freeze && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// each with a small SRAM model on its pins.

module tb_mem_sram_ctrl;

`ifdef SRAM_STALL_CNT_EN
  localparam logic [31:0] ExpStall2 = 32'd6;
`else
  localparam logic [31:0] ExpStall2 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic init;
  always #5 clk = ~clk;

  logic        rd1, wr1, ready1, freeze1, we1, oe1;
  logic [31:0] addr1, wdata1, rdata1, sc1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;

  logic        rd2, wr2, ready2, freeze2, we2, oe2;
  logic [31:0] addr2, wdata2, rdata2, sc2;
  logic [17:0] sa2;
  logic [15:0] dqo2, dqi2;

  mem_sram_ctrl #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .freeze(freeze1), .sram_addr(sa1), .sram_we_n(we1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1), .stall_count(sc1)
  );

  mem_sram_ctrl #(.WAIT_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .freeze(freeze2), .sram_addr(sa2), .sram_we_n(we2),
    .sram_dq_out(dqo2), .sram_dq_oe(oe2), .sram_dq_in(dqi2), .stall_count(sc2)
  );

  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];

  always @(posedge clk) begin
    if (init) begin
      mem1[4] <= 16'h1234;
      mem1[5] <= 16'hABCD;
      mem2[0] <= 16'h0F0F;
      mem2[1] <= 16'hC3C3;
    end else begin
      if (!we1 && oe1) mem1[sa1[3:0]] <= dqo1;
      if (!we2 && oe2) mem2[sa2[3:0]] <= dqo2;
    end
  end

  assign dqi1 = mem1[sa1[3:0]];
  assign dqi2 = mem2[sa2[3:0]];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One W=2 transaction on dut1, starting just after a rising edge (cycle 0).
  task automatic run1(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                      input int drop_c, input logic [17:0] lo_addr, input logic [31:0] exp_rd);
    logic hi;
    int   pos;
    rd1 = ~is_wr; wr1 = is_wr; addr1 = a; wdata1 = d;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq($sformatf("c%0d ready", c), {31'd0, ready1}, {31'd0, (c == 7)});
      check_eq($sformatf("c%0d freeze", c), {31'd0, freeze1}, {31'd0, (c != 7)});
      if (c >= 1 && c <= 6) begin
        hi  = (c >= 4);
        pos = (c - 1) % 3;
        check_eq($sformatf("c%0d sram_addr", c), {14'd0, sa1}, {14'd0, lo_addr + {17'd0, hi}});
        check_eq($sformatf("c%0d oe", c), {31'd0, oe1}, {31'd0, is_wr});
        check_eq($sformatf("c%0d we_n", c), {31'd0, we1}, {31'd0, ~is_wr | (pos == 2)});
        if (is_wr)
          check_eq($sformatf("c%0d dq_out", c), {16'd0, dqo1}, {16'd0, hi ? d[31:16] : d[15:0]});
      end else begin
        check_eq($sformatf("c%0d we_n idle", c), {31'd0, we1}, 32'd1);
        check_eq($sformatf("c%0d oe idle", c), {31'd0, oe1}, 32'd0);
      end
      if (c == 7 && !is_wr) check_eq("read rdata", rdata1, exp_rd);
      @(posedge clk);
      #1;
      if (c + 1 == drop_c) begin rd1 = 1'b0; wr1 = 1'b0; end
    end
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  // One W=0 transaction on dut2: ready expected in cycle 3.
  task automatic run2(input logic is_wr, input logic [31:0] a, input logic [31:0] d);
    rd2 = ~is_wr; wr2 = is_wr; addr2 = a; wdata2 = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("w0 c%0d ready", c), {31'd0, ready2}, {31'd0, (c == 3)});
      if (c == 1 || c == 2)
        check_eq($sformatf("w0 c%0d we_n", c), {31'd0, we2}, {31'd0, ~is_wr});
      @(posedge clk);
      #1;
    end
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b1;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    rd2 = 0; wr2 = 0; addr2 = '0; wdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    rst  = 1'b0;

    @(negedge clk);
    check_eq("rst ready", {31'd0, ready1}, 32'd1);
    check_eq("rst freeze", {31'd0, freeze1}, 32'd0);
    check_eq("rst we_n", {31'd0, we1}, 32'd1);
    check_eq("rst oe", {31'd0, oe1}, 32'd0);
    check_eq("rst rdata", rdata1, 32'd0);
    check_eq("rst sram_addr", {14'd0, sa1}, 32'd0);

    @(posedge clk); #1;
    run1(1'b1, 32'd1024, 32'hDEADBEEF, 8, 18'd0, 32'd0);
    check_eq("wr mem lo", {16'd0, mem1[0]}, 32'h0000BEEF);
    check_eq("wr mem hi", {16'd0, mem1[1]}, 32'h0000DEAD);

    run1(1'b0, 32'd1032, 32'd0, 8, 18'd4, 32'hABCD1234);

    // Request dropped in cycle 2: the write still finishes both halves.
    run1(1'b1, 32'd1028, 32'h5555AAAA, 2, 18'd2, 32'd0);
    check_eq("flush mem lo", {16'd0, mem1[2]}, 32'h0000AAAA);
    check_eq("flush mem hi", {16'd0, mem1[3]}, 32'h00005555);
    check_eq("rdata held over write", rdata1, 32'hABCD1234);

    // Reset in cycle 4 of a write (HI phase, we_n low).
    rd1 = 0; wr1 = 1; addr1 = 32'd1036; wdata1 = 32'h01020304;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre-rst we_n", {31'd0, we1}, 32'd0);
    rst = 1'b1; wr1 = 1'b0;
    #1;
    check_eq("async rst we_n", {31'd0, we1}, 32'd1);
    check_eq("async rst oe", {31'd0, oe1}, 32'd0);
    check_eq("async rst ready", {31'd0, ready1}, 32'd1);
    check_eq("async rst sram_addr", {14'd0, sa1}, 32'd0);
    check_eq("async rst rdata", rdata1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run2(1'b0, 32'd1024, 32'd0);
    check_eq("w0 rdata", rdata2, 32'hC3C30F0F);
    run2(1'b1, 32'd1028, 32'h11112222);
    @(negedge clk);
    check_eq("w0 mem lo", {16'd0, mem2[2]}, 32'h00002222);
    check_eq("w0 mem hi", {16'd0, mem2[3]}, 32'h00001111);
    check_eq("w0 stall_count", sc2, ExpStall2);
    check_eq("idle stall_count", sc1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
